fb_sram_scheduler: RTL and testbench

// - Owns the 16-bit async SRAM frame buffer. It shares the SRAM between the VGA scanline prefetch and the game pixel writer.
// - Double-buffered: the VGA side reads the front page; the renderer writes the back page; the two pages swap at vsync.
// - Sits between the draw/renderer logic, the scanline FIFO RAM and the SRAM_* pins.
// - Frame buffer format: 4-bit colour index, 4 pixels per 16-bit word.

---
 rtl/fb_sram_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_fb_sram_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sram_scheduler.sv
// Double-buffered 16-bit async SRAM frame buffer: scanline prefetch from the front page, pixel writes to the back page.
// Optional back-page auto-clear after each flip is enabled by defining FB_AUTOCLEAR_EN.
module fb_sram_scheduler #(
  parameter int          H_WORDS    = 160,
  parameter int          V_LINES    = 480,
  parameter int          PAGE_BIT   = 17,
  parameter logic [15:0] CLEAR_WORD = 16'h0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        line_req,
  input  logic [9:0]  line_y,
  output logic        fifo_we,
  output logic [7:0]  fifo_addr,
  output logic [15:0] fifo_data,
  output logic        line_done,
  output logic        line_overrun,
  input  logic        wr_req,
  input  logic [7:0]  wr_x,
  input  logic [8:0]  wr_y,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        flip_req,
  input  logic        vsync_start,
  output logic        front_page,
  output logic        flip_done,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  typedef enum logic [3:0] {
    IDLE, RD_ADDR, RD_DATA, WR_SETUP, WR_PULSE, WR_HOLD
`ifdef FB_AUTOCLEAR_EN
    , CLR_SETUP, CLR_PULSE, CLR_HOLD
`endif
  } state_t;

  state_t      state;
  logic [7:0]  rd_x;
  logic        line_pend, fetching, flip_pend, flip_defer, dq_oe;
  logic [9:0]  pend_y;
  logic [15:0] dq_out;
`ifdef FB_AUTOCLEAR_EN
  logic        clearing;
  logic [16:0] clr_off;
`endif

  logic        busy, fetch_go, go_in, wr_in, wr_go, done_evt, flip_now;
  logic [9:0]  go_y;
  logic [16:0] go_off, wr_off;

  function automatic logic [19:0] sram_addr(input logic page, input logic [16:0] off);
    return 20'(off) | (20'(page) << PAGE_BIT);
  endfunction

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

  // A pending (not yet started) fetch counts as busy, so a second request is an overrun.
  assign busy     = fetching || line_pend;
  assign go_y     = line_pend ? pend_y : line_y;
  assign go_in    = go_y < 10'(V_LINES);
  assign go_off   = 17'(go_y) * 17'(H_WORDS);
  assign fetch_go = (state == IDLE) && (line_pend || (line_req && !fetching));
  assign wr_in    = (wr_x < 8'(H_WORDS)) && (wr_y < 9'(V_LINES));
  assign wr_off   = 17'(wr_y) * 17'(H_WORDS) + 17'(wr_x);
  assign wr_go    = wr_req && !wr_ack && !fetching;
  assign done_evt = (fetching && fifo_we && fifo_addr == 8'(H_WORDS - 1)) || (fetch_go && !go_in);
  assign flip_now = (vsync_start && (flip_pend || flip_req) && !busy) || (flip_defer && done_evt);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      rd_x         <= '0;
      line_pend    <= 1'b0;
      pend_y       <= '0;
      fetching     <= 1'b0;
      flip_pend    <= 1'b0;
      flip_defer   <= 1'b0;
      dq_oe        <= 1'b0;
      dq_out       <= CLEAR_WORD;
      fifo_we      <= 1'b0;
      fifo_addr    <= '0;
      fifo_data    <= '0;
      line_done    <= 1'b0;
      line_overrun <= 1'b0;
      wr_ack       <= 1'b0;
      front_page   <= 1'b0;
      flip_done    <= 1'b0;
      SRAM_ADDR    <= '0;
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
`ifdef FB_AUTOCLEAR_EN
      clearing     <= 1'b0;
      clr_off      <= '0;
`endif
    end else begin
      fifo_we   <= 1'b0;
      wr_ack    <= 1'b0;
      line_done <= done_evt;
      flip_done <= flip_now;
      if (line_req && busy) line_overrun <= 1'b1;
      if (done_evt) fetching <= 1'b0;
      if (line_req && !busy && !fetch_go) begin
        line_pend <= 1'b1;
        pend_y    <= line_y;
      end
      if (flip_now) begin
        front_page <= ~front_page;
        flip_pend  <= 1'b0;
        flip_defer <= 1'b0;
      end else begin
        if (flip_req) flip_pend <= 1'b1;
        if (vsync_start && (flip_pend || flip_req)) flip_defer <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fetch_go) begin
            line_pend <= 1'b0;
            if (go_in) begin
              fetching  <= 1'b1;
              rd_x      <= '0;
              SRAM_ADDR <= sram_addr(front_page, go_off);
              SRAM_OE_N <= 1'b0;
              state     <= RD_ADDR;
            end
          end
`ifdef FB_AUTOCLEAR_EN
          else if (clearing) begin
            SRAM_ADDR <= sram_addr(~front_page, clr_off);
            dq_out    <= CLEAR_WORD;
            dq_oe     <= 1'b1;
            state     <= CLR_SETUP;
          end
`endif
          else if (wr_go) begin
            if (wr_in) begin
              SRAM_ADDR <= sram_addr(~front_page, wr_off);
              dq_out    <= wr_data;
              dq_oe     <= 1'b1;
              state     <= WR_SETUP;
            end else begin
              wr_ack <= 1'b1;
            end
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          fifo_we   <= 1'b1;
          fifo_data <= SRAM_DQ;
          fifo_addr <= rd_x;
          if (rd_x == 8'(H_WORDS - 1)) begin
            SRAM_OE_N <= 1'b1;
            state     <= IDLE;
          end else begin
            rd_x      <= rd_x + 8'd1;
            SRAM_ADDR <= SRAM_ADDR + 20'd1;
            state     <= RD_ADDR;
          end
        end
        WR_SETUP: begin
          SRAM_WE_N <= 1'b0;
          state     <= WR_PULSE;
        end
        WR_PULSE: begin
          SRAM_WE_N <= 1'b1;
          wr_ack    <= 1'b1;
          state     <= WR_HOLD;
        end
        WR_HOLD: begin
          dq_oe <= 1'b0;
          state <= IDLE;
        end
`ifdef FB_AUTOCLEAR_EN
        CLR_SETUP: begin
          SRAM_WE_N <= 1'b0;
          state     <= CLR_PULSE;
        end
        CLR_PULSE: begin
          SRAM_WE_N <= 1'b1;
          state     <= CLR_HOLD;
        end
        CLR_HOLD: begin
          dq_oe <= 1'b0;
          state <= IDLE;
          if (clr_off == 17'(H_WORDS * V_LINES - 1)) clearing <= 1'b0;
          else clr_off <= clr_off + 17'd1;
        end
`endif
        default: state <= IDLE;
      endcase

`ifdef FB_AUTOCLEAR_EN
      // A new flip restarts the fill from word 0 of the new back page.
      if (flip_now) begin
        clearing <= 1'b1;
        clr_off  <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fb_sram_scheduler.sv
// Self-checking bench for fb_sram_scheduler: SRAM model, shadow frame-buffer model, directed and random steps.
module tb_fb_sram_scheduler;
  logic        Clk = 1'b0, Reset_n = 1'b0;
  logic        line_req = 1'b0, wr_req = 1'b0, flip_req = 1'b0, vsync_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic [7:0]  wr_x = '0;
  logic [8:0]  wr_y = '0;
  logic [15:0] wr_data = '0;
  logic        fifo_we, line_done, line_overrun, wr_ack, front_page, flip_done;
  logic [7:0]  fifo_addr;
  logic [15:0] fifo_data;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;

  fb_sram_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_req(line_req), .line_y(line_y),
    .fifo_we(fifo_we), .fifo_addr(fifo_addr), .fifo_data(fifo_data),
    .line_done(line_done), .line_overrun(line_overrun),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
    .flip_req(flip_req), .vsync_start(vsync_start), .front_page(front_page), .flip_done(flip_done),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
  );

  always #10 Clk = ~Clk;

  // Async SRAM model: unwritten words hold a fixed address hash.
  bit [15:0]   mem [262144];
  bit          wrote [262144];
  bit [15:0]   dq_drv;
  logic [15:0] shadow [262144];
  bit          mfront = 1'b0;
  int          n_cmp = 0, n_err = 0;

  function automatic logic [15:0] iw(input int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  function automatic logic [19:0] paddr(input bit pg, input int y, input int x);
    return 20'((pg ? 131072 : 0) + y * 160 + x);
  endfunction

  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? dq_drv : 16'bz;
  always @(negedge Clk) dq_drv <= wrote[SRAM_ADDR[17:0]] ? mem[SRAM_ADDR[17:0]] : iw(int'(SRAM_ADDR[17:0]));
  always @(posedge Clk)
    if (!SRAM_WE_N && !SRAM_CE_N) begin
      mem[SRAM_ADDR[17:0]]   <= SRAM_DQ;
      wrote[SRAM_ADDR[17:0]] <= 1'b1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we_n"}, SRAM_WE_N, 1);
    chk({tag, "_oe_n"}, SRAM_OE_N, 1);
    chk({tag, "_ce_ub_lb"}, {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 0);
    chk({tag, "_dq_z"}, SRAM_DQ, 32'h0000_zzzz);
    chk({tag, "_addr"}, SRAM_ADDR, 0);
    chk({tag, "_front"}, front_page, 0);
    chk({tag, "_overrun"}, line_overrun, 0);
    chk({tag, "_pulses"}, {fifo_we, line_done, wr_ack, flip_done}, 0);
  endtask

  task automatic do_write(input int x, input int y, input logic [15:0] d);
    bit inr = (x < 160) && (y < 480);
    int welow = 0, ack_c = -1;
    logic [19:0] a = paddr(!mfront, y, x);
    wr_x = 8'(x); wr_y = 9'(y); wr_data = d; wr_req = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) begin
        welow++;
        chk("wr_addr", SRAM_ADDR, a);
        chk("wr_dq", SRAM_DQ, 32'(d));
      end
      if (wr_ack) begin ack_c = c; wr_req = 1'b0; break; end
      step();
    end
    wr_req = 1'b0;
    step();
    chk("wr_ack_once", wr_ack, 0);
    chk("wr_dq_release", SRAM_DQ, 32'h0000_zzzz);
    chk("wr_we_low_cycles", welow, inr ? 1 : 0);
    chk("wr_ack_cycle", ack_c, inr ? 3 : 1);
    if (inr) shadow[18'(a)] = d;
  endtask

  task automatic do_fetch(input int y);
    bit inr = (y < 480), first_addr = 1'b1;
    int nwe = 0, first = -1, last = -1, done_c = -1, oe_low = 0;
    logic [19:0] base = paddr(mfront, y, 0);
    line_y = 10'(y); line_req = 1'b1;
    for (int c = 0; c < 700; c++) begin
      @(negedge Clk);
      if (!SRAM_OE_N) begin
        oe_low++;
        if (first_addr) begin chk("rd_first_addr", SRAM_ADDR, base); first_addr = 1'b0; end
        chk("rd_addr_in_line", (SRAM_ADDR >= base) && (SRAM_ADDR < base + 20'd160), 1);
      end
      if (fifo_we) begin
        chk("fifo_addr", fifo_addr, nwe);
        chk("fifo_data", fifo_data, shadow[18'(base + 20'(nwe))]);
        if (first < 0) first = c;
        last = c;
        nwe++;
      end
      if (line_done) begin done_c = c; break; end
      step();
      line_req = 1'b0;
    end
    line_req = 1'b0;
    step();
    chk("line_done_pulse", line_done, 0);
    chk("fetch_words", nwe, inr ? 160 : 0);
    chk("line_done_cycle", done_c, inr ? 322 : 1);
    if (inr) begin
      chk("first_fifo_we_cycle", first, 3);
      chk("last_fifo_we_cycle", last, 321);
    end else chk("oor_no_access", oe_low, 0);
  endtask

  task automatic do_flip(input bit same_cycle);
    if (!same_cycle) begin flip_req = 1'b1; step(); flip_req = 1'b0; end
    flip_req = same_cycle; vsync_start = 1'b1;
    step();
    flip_req = 1'b0; vsync_start = 1'b0;
    chk("flip_done", flip_done, 1);
    chk("flip_front", front_page, !mfront);
    mfront = !mfront;
    step();
    chk("flip_done_pulse", flip_done, 0);
  endtask

  task automatic do_vsync_noflip();
    vsync_start = 1'b1;
    step();
    vsync_start = 1'b0;
    chk("noflip_done", flip_done, 0);
    chk("noflip_front", front_page, mfront);
  endtask

  // wr_req at c=0, line_req at c=1, overrun request, deferred flip and a stalled write during the fetch.
  task automatic do_conflict();
    bit old = mfront;
    int first = -1, done_c = -1, ack1 = -1, ack2 = -1, nwe = 0, we1 = 0, we_bad = 0, we2 = 0;
    logic [19:0] rbase = paddr(old, 10, 0), a1 = paddr(!old, 10, 7), a2 = paddr(old, 10, 8);
    for (int c = 0; c < 800; c++) begin
      if (c == 0) begin wr_x = 8'd7; wr_y = 9'd10; wr_data = 16'h1357; wr_req = 1'b1; end
      if (c == 40) begin wr_x = 8'd8; wr_y = 9'd10; wr_data = 16'h2468; wr_req = 1'b1; end
      line_req = (c == 1) || (c == 20);
      line_y = (c == 20) ? 10'd3 : 10'd10;
      flip_req = (c == 25);
      vsync_start = (c == 30);
      @(negedge Clk);
      if (c == 35) chk("cf_flip_deferred", front_page, old);
      if (!SRAM_WE_N) begin
        if (ack1 < 0) begin we1++; chk("cf_wr1_addr", SRAM_ADDR, a1); end
        else if (done_c < 0) we_bad++;
        else begin we2++; chk("cf_wr2_addr", SRAM_ADDR, a2); end
      end
      if (fifo_we) begin
        chk("cf_fifo_data", fifo_data, shadow[18'(rbase + 20'(nwe))]);
        if (first < 0) first = c;
        nwe++;
      end
      if (line_done) begin
        done_c = c;
        chk("cf_flip_at_done", {flip_done, front_page}, {1'b1, !old});
      end
      if (wr_ack) begin
        wr_req = 1'b0;
        if (ack1 < 0) begin ack1 = c; shadow[18'(a1)] = 16'h1357; end
        else begin ack2 = c; shadow[18'(a2)] = 16'h2468; break; end
      end
      step();
    end
    line_req = 1'b0; flip_req = 1'b0; vsync_start = 1'b0; wr_req = 1'b0;
    step();
    chk("cf_ack1_cycle", ack1, 3);
    chk("cf_wr1_we_low", we1, 1);
    chk("cf_fetch_started", first >= 0, 1);
    chk("cf_fetch_latency", (first - 1) <= 6, 1);
    chk("cf_words", nwe, 160);
    chk("cf_done_after_last", done_c, first + 319);
    chk("cf_no_write_in_fetch", we_bad, 0);
    chk("cf_wr2_after_done", ack2 > done_c, 1);
    chk("cf_wr2_we_low", we2, 1);
    chk("cf_overrun", line_overrun, 1);
    mfront = !old;
  endtask

  initial begin
    int r, x, y;
    for (int a = 0; a < 262144; a++) shadow[a] = iw(a);
    step(); step();
    chk_reset("rst");
    Reset_n = 1'b1;
    step();

    do_write(3, 2, 16'hABCD);
    do_fetch(5);
    do_fetch(480);
    do_write(160, 0, 16'h1111);
    do_write(0, 480, 16'h2222);
    do_vsync_noflip();
    do_flip(1'b0);
    do_fetch(2);
    do_flip(1'b1);
    do_conflict();
    do_fetch(10);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        x = ($urandom_range(0, 15) == 0) ? $urandom_range(160, 255) : $urandom_range(0, 159);
        y = ($urandom_range(0, 15) == 0) ? $urandom_range(480, 511) : $urandom_range(20, 23);
        do_write(x, y, 16'($urandom));
      end else if (r <= 7) begin
        y = ($urandom_range(0, 7) == 0) ? $urandom_range(480, 1023) : $urandom_range(20, 23);
        do_fetch(y);
      end else if (r == 8) do_flip(1'($urandom_range(0, 1)));
      else do_vsync_noflip();
    end

    // Reset in the middle of the write pulse must release the bus immediately.
    wr_x = 8'd5; wr_y = 9'd5; wr_data = 16'hFFFF; wr_req = 1'b1;
    step(); step();
    chk("pre_reset_we_low", SRAM_WE_N, 0);
    #3 Reset_n = 1'b0;
    #1;
    chk_reset("midwr");
    wr_req = 1'b0;
    step(); step();
    Reset_n = 1'b1;
    mfront = 1'b0;
    step();
    do_fetch(21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
